rf_wb_arbiter: RTL and testbench

- Owns the single register-file write port (A3/WE3/WD3) and shares it between two writeback requesters: the ALU (single-cycle results) and the LSU (load returns).
- Arbitrates round-robin on contention and registers the winning write for one cycle before it reaches the RF.
- Keeps a pending-destination scoreboard and an outstanding-load counter, and drives the decode-stage stall.
- Sits between EX/MEM writeback and the RF.

---
 rtl/rf_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: round-robin ALU/LSU writeback arbitration,
// one-cycle registered write, pending-load scoreboard and decode stall.
module rf_wb_arbiter #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned MAX_LD = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_wd,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_wd,
   input  logic            ld_issue,
   input  logic [4:0]      ld_rd,
   input  logic [4:0]      dec_rs1,
   input  logic [4:0]      dec_rs2,
   input  logic [4:0]      dec_rd,
   output logic            stall,
   output logic            ld_full,
   output logic            rf_we,
   output logic [4:0]      rf_a3,
   output logic [XLEN-1:0] rf_wd
);

   localparam int unsigned CNT_W = $clog2(MAX_LD + 1);

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } src_t;

   logic             wb_valid;
   src_t             wb_src;
   src_t             last_grant;
   logic [31:0]      pending;
   logic [31:0]      pending_nxt;
   logic [CNT_W-1:0] ld_cnt;
   logic [CNT_W-1:0] ld_cnt_nxt;

   logic             grant_any;
   src_t             win_src;
   logic [4:0]       win_rd;
   logic [XLEN-1:0]  win_wd;
   logic             commit;
   logic             issue_ok;

   // Round-robin grant: on contention the requester that did not win last time goes.
   always_comb begin
      alu_ready = alu_valid && (!lsu_valid || (last_grant == SRC_LSU));
      lsu_ready = lsu_valid && (!alu_valid || (last_grant == SRC_ALU));
      grant_any = alu_ready || lsu_ready;
      win_src   = lsu_ready ? SRC_LSU : SRC_ALU;
      win_rd    = lsu_ready ? lsu_rd : alu_rd;
      win_wd    = lsu_ready ? lsu_wd : alu_wd;
   end

   assign commit   = wb_valid && (wb_src == SRC_LSU);
   assign issue_ok = ld_issue && (ld_cnt < CNT_W'(MAX_LD));
   assign ld_full  = (ld_cnt == CNT_W'(MAX_LD));

   // Scoreboard next state; a same-register issue overrides the commit clear.
   always_comb begin
      pending_nxt = pending;
      ld_cnt_nxt  = ld_cnt;
      if (commit) begin
         pending_nxt[rf_a3] = 1'b0;
      end
      if (issue_ok && (ld_rd != 5'd0)) begin
         pending_nxt[ld_rd] = 1'b1;
      end
      if (issue_ok && !commit) begin
         ld_cnt_nxt = ld_cnt + CNT_W'(1);
      end else if (commit && !issue_ok && (ld_cnt != CNT_W'(0))) begin
         ld_cnt_nxt = ld_cnt - CNT_W'(1);
      end
   end

   // Hold decode on in-flight loads and on the write still sitting in the stage.
   always_comb begin
      stall = 1'b0;
      if (dec_rs1 != 5'd0) begin
         stall = stall || pending[dec_rs1] || (wb_valid && (rf_a3 == dec_rs1));
      end
      if (dec_rs2 != 5'd0) begin
         stall = stall || pending[dec_rs2] || (wb_valid && (rf_a3 == dec_rs2));
      end
      if (dec_rd != 5'd0) begin
         stall = stall || pending[dec_rd];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid   <= 1'b0;
         wb_src     <= SRC_ALU;
         last_grant <= SRC_LSU;
         rf_we      <= 1'b0;
         rf_a3      <= 5'd0;
         rf_wd      <= '0;
         pending    <= '0;
         ld_cnt     <= '0;
      end else begin
         wb_valid <= grant_any;
         rf_we    <= grant_any && (win_rd != 5'd0);
         if (grant_any) begin
            wb_src     <= win_src;
            last_grant <= win_src;
            rf_a3      <= win_rd;
            rf_wd      <= win_wd;
         end
         pending <= pending_nxt;
         ld_cnt  <= ld_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a rule-level model.
module tb_rf_wb_arbiter;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned MAX_LD = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            alu_valid, lsu_valid, ld_issue;
   logic            alu_ready, lsu_ready, stall, ld_full, rf_we;
   logic [4:0]      alu_rd, lsu_rd, ld_rd, dec_rs1, dec_rs2, dec_rd, rf_a3;
   logic [XLEN-1:0] alu_wd, lsu_wd, rf_wd;

   rf_wb_arbiter #(.XLEN(XLEN), .MAX_LD(MAX_LD)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
      .ld_issue(ld_issue), .ld_rd(ld_rd),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .stall(stall), .ld_full(ld_full),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: who won last (1 = LSU), the staged write, scoreboard bits, load count.
   bit          m_last;
   bit          m_wb_v;
   bit          m_wb_lsu;
   logic [4:0]  m_a3;
   logic [31:0] m_wd;
   logic [31:0] m_pend;
   int          m_cnt;
   logic [4:0]  ldq[$];
   logic [31:0] cnt_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last   = 1'b1;
      m_wb_v   = 1'b0;
      m_wb_lsu = 1'b0;
      m_a3     = 5'd0;
      m_wd     = 32'd0;
      m_pend   = 32'd0;
      m_cnt    = 0;
      ldq.delete();
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_rd = 5'd0; alu_wd = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_wd = 32'd0;
      ld_issue  = 1'b0; ld_rd  = 5'd0;
      dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
   endtask

   function automatic bit src_hazard(input logic [4:0] r);
      return (r != 5'd0) && (m_pend[r] || (m_wb_v && (m_a3 == r)));
   endfunction

   // One clock: check all outputs against the model, then advance the model over the edge.
   task automatic cycle();
      bit ga, gl, st, commit, iss;
      #1;
      ga = alu_valid && (!lsu_valid || m_last);
      gl = lsu_valid && (!alu_valid || !m_last);
      st = src_hazard(dec_rs1) || src_hazard(dec_rs2) || ((dec_rd != 5'd0) && m_pend[dec_rd]);
      check("alu_ready", 32'(alu_ready), 32'(ga));
      check("lsu_ready", 32'(lsu_ready), 32'(gl));
      check("stall", 32'(stall), 32'(st));
      check("ld_full", 32'(ld_full), 32'(m_cnt == MAX_LD));
      check("rf_we", 32'(rf_we), 32'(m_wb_v && (m_a3 != 5'd0)));
      check("rf_a3", 32'(rf_a3), 32'(m_a3));
      check("rf_wd", rf_wd, m_wd);
      check("ld_cnt", 32'(dut.ld_cnt), 32'(m_cnt));
      check("pending", dut.pending, m_pend);
      cnt_seen = 32'(dut.ld_cnt);
      @(posedge clk);
      commit = m_wb_v && m_wb_lsu;
      iss    = ld_issue && (m_cnt < MAX_LD);
      if (commit) check("commit_has_load", 32'(cnt_seen != 0), 32'd1);
      if (commit) m_pend[m_a3] = 1'b0;
      if (iss && (ld_rd != 5'd0)) m_pend[ld_rd] = 1'b1;
      if (iss && !commit) m_cnt++;
      else if (commit && !iss && (m_cnt > 0)) m_cnt--;
      if (iss) ldq.push_back(ld_rd);
      if (gl && (ldq.size() > 0)) void'(ldq.pop_front());
      if (ga) begin
         m_wb_v = 1'b1; m_wb_lsu = 1'b0; m_a3 = alu_rd; m_wd = alu_wd; m_last = 1'b0;
      end else if (gl) begin
         m_wb_v = 1'b1; m_wb_lsu = 1'b1; m_a3 = lsu_rd; m_wd = lsu_wd; m_last = 1'b1;
      end else begin
         m_wb_v = 1'b0;
      end
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between edges; effect must be immediate.
   task automatic reset_dut();
      idle();
      #2 rst_n = 1'b0;
      #1;
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_pending", dut.pending, 32'd0);
      check("rst_ld_cnt", 32'(dut.ld_cnt), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      model_reset();
      reset_dut();
      cycle();

      // ALU only: write visible one cycle after the handshake
      alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
      cycle();
      idle();
      check("alu_we", 32'(rf_we), 32'd1);
      check("alu_a3", 32'(rf_a3), 32'd5);
      check("alu_wd", rf_wd, 32'hDEADBEEF);
      cycle();
      check("alu_we_drop", 32'(rf_we), 32'd0);

      // Contention after reset: ALU first, then alternate
      reset_dut();
      ld_issue = 1'b1; ld_rd = 5'd2;
      cycle();
      cycle();
      idle();
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'(100 + i);
         lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wd = 32'(200 + i);
         #1 check("cont_alu_grant", 32'(alu_ready), 32'((i % 2) == 0));
         #0;
         cycle();
         check("cont_a3", 32'(rf_a3), (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      idle();
      cycle();

      // Load hazard on rs2 held through handshake and write cycles
      ld_issue = 1'b1; ld_rd = 5'd7;
      cycle();
      idle(); dec_rs2 = 5'd7;
      cycle();
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h0000_7777;
      cycle();
      lsu_valid = 1'b0;
      check("haz_wb_stall", 32'(stall), 32'd1);
      cycle();
      check("haz_clear", 32'(stall), 32'd0);
      check("haz_cnt", 32'(dut.ld_cnt), 32'd0);
      cycle();

      // Fill to MAX_LD, reject an issue when full, then issue/commit overlap
      idle();
      for (int i = 0; i < 4; i++) begin
         ld_issue = 1'b1; ld_rd = 5'(8 + i);
         cycle();
      end
      check("full_flag", 32'(ld_full), 32'd1);
      ld_issue = 1'b1; ld_rd = 5'd12;
      cycle();
      check("full_no_set", 32'(dut.pending[12]), 32'd0);
      check("full_no_inc", 32'(dut.ld_cnt), 32'd4);
      ld_issue = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_wd = 32'h8;
      cycle();
      ld_issue = 1'b1; ld_rd = 5'd12; lsu_rd = 5'd9; lsu_wd = 32'h9;
      cycle();
      lsu_valid = 1'b0;
      cycle();
      check("ovl_set", 32'(dut.pending[12]), 32'd1);
      check("ovl_cnt", 32'(dut.ld_cnt), 32'd3);
      ld_issue = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'hA;
      cycle();
      lsu_valid = 1'b0; ld_issue = 1'b1; ld_rd = 5'd10;
      cycle();
      check("set_wins", 32'(dut.pending[10]), 32'd1);
      idle();

      // Register 0 paths
      reset_dut();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'h1234;
      cycle();
      idle();
      check("x0_alu_we", 32'(rf_we), 32'd0);
      ld_issue = 1'b1; ld_rd = 5'd0;
      cycle();
      idle();
      check("x0_ld_cnt", 32'(dut.ld_cnt), 32'd1);
      check("x0_ld_pend", dut.pending, 32'd0);
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h55;
      cycle();
      idle(); dec_rs1 = 5'd0;
      check("x0_lsu_we", 32'(rf_we), 32'd0);
      check("x0_no_stall", 32'(stall), 32'd0);
      cycle();

      // Async reset while a write is staged
      alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'hCAFE;
      ld_issue = 1'b1; ld_rd = 5'd4;
      cycle();
      check("pre_rst_we", 32'(rf_we), 32'd1);
      reset_dut();
      cycle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         alu_valid = 1'($urandom_range(0, 1));
         alu_rd    = 5'($urandom_range(0, 7));
         alu_wd    = $urandom;
         lsu_valid = (ldq.size() > 0) && ($urandom_range(0, 2) != 0);
         lsu_rd    = (ldq.size() > 0) ? ldq[0] : 5'd0;
         lsu_wd    = $urandom;
         ld_issue  = ($urandom_range(0, 2) == 0);
         ld_rd     = 5'($urandom_range(0, 7));
         dec_rs1   = 5'($urandom_range(0, 7));
         dec_rs2   = 5'($urandom_range(0, 7));
         dec_rd    = 5'($urandom_range(0, 7));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
